// File: rtl/logical_arbiter.sv
// logical_arbiter: round-robin sharing of one XOR/OR/AND unit between two requesters with a registered, ID-tagged response
module logical_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_x,
  input  logic [XLEN-1:0] req0_y,
  input  logic [2:0]      req0_funct3,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_x,
  input  logic [XLEN-1:0] req1_y,
  input  logic [2:0]      req1_funct3,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err
);
  localparam logic EMPTY = 1'b0;
  localparam logic FULL = 1'b1;
  localparam logic [2:0] F_XOR = 3'b100;
  localparam logic [2:0] F_OR = 3'b110;
  localparam logic [2:0] F_AND = 3'b111;
  logic state_q, state_d;
  logic last_grant_q, last_grant_d;
  logic rsp_id_q, rsp_id_d;
  logic rsp_err_q, rsp_err_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic can_accept, gnt0, gnt1, grant;
  logic [XLEN-1:0] op_x, op_y, op_res;
  logic [2:0] op_f;
  logic op_err;
  // grant only when the response stage is empty or being drained; on contention favour the requester not served last
  always_comb begin
    can_accept = state_q == EMPTY || rsp_ready;
    gnt0 = can_accept && req0_valid && (!req1_valid || last_grant_q);
    gnt1 = can_accept && req1_valid && (!req0_valid || !last_grant_q);
    grant = gnt0 || gnt1;
  end
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  // shared logical unit fed by the granted requester; illegal funct3 yields zero with an error flag
  always_comb begin
    op_x = gnt1 ? req1_x : req0_x;
    op_y = gnt1 ? req1_y : req0_y;
    op_f = gnt1 ? req1_funct3 : req0_funct3;
    op_err = op_f != F_XOR && op_f != F_OR && op_f != F_AND;
    op_res = op_f == F_XOR ? op_x ^ op_y :
             op_f == F_OR  ? op_x | op_y :
             op_f == F_AND ? op_x & op_y : '0;
  end
  // response stage fills on grant, empties on drain without refill, otherwise holds
  always_comb begin
    state_d = grant ? FULL : (rsp_ready ? EMPTY : state_q);
    last_grant_d = grant ? gnt1 : last_grant_q;
    rsp_id_d = grant ? gnt1 : rsp_id_q;
    rsp_data_d = grant ? op_res : rsp_data_q;
    rsp_err_d = grant ? op_err : rsp_err_q;
  end
  // state registers; reset discards any pending response and restores req0 priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      last_grant_q <= 1'b1;
      rsp_id_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_valid = state_q == FULL;
  assign rsp_id = rsp_id_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err = rsp_err_q;
endmodule

// File: tb/tb_logical_arbiter.sv
// tb_logical_arbiter: vector table, directed corner sequences and random traffic against a rule-level model
module tb_logical_arbiter;
  logic clk, rst_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_x, req0_y, req1_x, req1_y;
  logic [2:0] req0_funct3, req1_funct3;
  logic rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_data;
  int total = 0;
  int bad = 0;
  logic m_v, m_id, m_err, m_last;
  logic [31:0] m_d;
  logic s_r0, s_r1;
  typedef struct {
    logic v0, v1;
    logic [2:0] f0, f1;
    logic [31:0] x0, y0, x1, y1;
    logic rdy;
    logic e_r0, e_r1, e_v, e_id;
    logic [31:0] e_d;
    logic e_err;
  } vec_t;
  vec_t tbl[6];
  logical_arbiter #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_funct3(req0_funct3),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_funct3(req1_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    case (f)
      3'b100: return x ^ y;
      3'b110: return x | y;
      3'b111: return x & y;
      default: return 32'h0;
    endcase
  endfunction
  function automatic logic ref_err(input logic [2:0] f);
    return !(f == 3'b100 || f == 3'b110 || f == 3'b111);
  endfunction
  task automatic model_reset();
    m_v = 0; m_id = 0; m_err = 0; m_d = 0; m_last = 1;
  endtask
  task automatic cyc(input logic v0, input logic v1, input logic [2:0] f0, input logic [2:0] f1,
                     input logic [31:0] x0, input logic [31:0] y0, input logic [31:0] x1, input logic [31:0] y1,
                     input logic rdy);
    logic can, any, who;
    req0_valid = v0; req1_valid = v1; req0_funct3 = f0; req1_funct3 = f1;
    req0_x = x0; req0_y = y0; req1_x = x1; req1_y = y1; rsp_ready = rdy;
    @(negedge clk);
    can = !m_v || rdy;
    any = can && (v0 || v1);
    who = (v0 && v1) ? !m_last : v1;
    s_r0 = req0_ready; s_r1 = req1_ready;
    chk("req0_ready", 32'(req0_ready), 32'(any && !who));
    chk("req1_ready", 32'(req1_ready), 32'(any && who));
    @(posedge clk);
    if (any) begin
      m_v = 1; m_id = who; m_last = who;
      m_d = who ? ref_op(f1, x1, y1) : ref_op(f0, x0, y0);
      m_err = who ? ref_err(f1) : ref_err(f0);
    end else if (rdy) m_v = 0;
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_v));
    if (m_v) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_data", rsp_data, m_d);
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
    end
  endtask
  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_x = 0; req0_y = 0; req1_x = 0; req1_y = 0; req0_funct3 = 0; req1_funct3 = 0;
  endtask
  initial begin
    logic [2:0] rf0, rf1;
    tbl[0] = '{1, 0, 3'b100, 3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 1, 1, 0, 1, 0, 32'hFF00FF00, 0};
    tbl[1] = '{1, 1, 3'b111, 3'b110, 32'hFFFF0000, 32'h12345678, 32'h000000FF, 32'h00000F00, 1, 0, 1, 1, 1, 32'h00000FFF, 0};
    tbl[2] = '{1, 1, 3'b111, 3'b110, 32'hFFFF0000, 32'h12345678, 32'h000000FF, 32'h00000F00, 1, 1, 0, 1, 0, 32'h12340000, 0};
    tbl[3] = '{1, 1, 3'b111, 3'b110, 32'hFFFF0000, 32'h12345678, 32'h000000FF, 32'h00000F00, 1, 0, 1, 1, 1, 32'h00000FFF, 0};
    tbl[4] = '{1, 1, 3'b111, 3'b110, 32'hFFFF0000, 32'h12345678, 32'h000000FF, 32'h00000F00, 1, 1, 0, 1, 0, 32'h12340000, 0};
    tbl[5] = '{0, 1, 3'b000, 3'b000, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 1, 1, 1, 32'h00000000, 1};
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_id", 32'(rsp_id), 0);
    chk("reset rsp_data", rsp_data, 0);
    chk("reset rsp_err", 32'(rsp_err), 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].v0, tbl[i].v1, tbl[i].f0, tbl[i].f1, tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].rdy);
      chk($sformatf("tbl%0d r0", i), 32'(s_r0), 32'(tbl[i].e_r0));
      chk($sformatf("tbl%0d r1", i), 32'(s_r1), 32'(tbl[i].e_r1));
      chk($sformatf("tbl%0d valid", i), 32'(rsp_valid), 32'(tbl[i].e_v));
      chk($sformatf("tbl%0d id", i), 32'(rsp_id), 32'(tbl[i].e_id));
      chk($sformatf("tbl%0d data", i), rsp_data, tbl[i].e_d);
      chk($sformatf("tbl%0d err", i), 32'(rsp_err), 32'(tbl[i].e_err));
    end
    cyc(1, 0, 3'b100, 3'b000, 32'hAAAA5555, 0, 0, 0, 1);
    chk("stall load", rsp_data, 32'hAAAA5555);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 3'b110, 3'b111, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0);
      chk("stall r0", 32'(s_r0), 0);
      chk("stall r1", 32'(s_r1), 0);
      chk("stall data", rsp_data, 32'hAAAA5555);
      chk("stall valid", 32'(rsp_valid), 1);
    end
    cyc(1, 1, 3'b110, 3'b111, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1);
    chk("drain refill r1", 32'(s_r1), 1);
    chk("drain refill id", 32'(rsp_id), 1);
    chk("drain refill data", rsp_data, 32'h00000000 | (32'h33333333 & 32'h44444444));
    cyc(1, 0, 3'b110, 3'b000, 32'h0000FFFF, 32'hFFFF0000, 0, 0, 1);
    chk("pre-reset valid", 32'(rsp_valid), 1);
    idle_inputs();
    #2 rst_n = 0;
    #1;
    chk("async reset valid", 32'(rsp_valid), 0);
    chk("async reset data", rsp_data, 0);
    model_reset();
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    cyc(1, 1, 3'b100, 3'b100, 32'h1, 32'h2, 32'h4, 32'h8, 1);
    chk("post-reset first grant r0", 32'(s_r0), 1);
    chk("post-reset first data", rsp_data, 32'h3);
    cyc(0, 1, 3'b000, 3'b100, 0, 0, 32'h5, 32'h6, 1);
    chk("fair grant r1", 32'(s_r1), 1);
    cyc(0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 1);
    cyc(0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 1);
    cyc(1, 1, 3'b111, 3'b111, 32'hF0, 32'hFF, 32'h0F, 32'hFF, 1);
    chk("fair after idle r0", 32'(s_r0), 1);
    chk("fair after idle id", 32'(rsp_id), 0);
    for (int i = 0; i < 400; i++) begin
      int p0, p1;
      p0 = $urandom_range(0, 4);
      p1 = $urandom_range(0, 4);
      rf0 = p0 == 0 ? 3'b100 : p0 == 1 ? 3'b110 : p0 == 2 ? 3'b111 : 3'($urandom);
      rf1 = p1 == 0 ? 3'b100 : p1 == 1 ? 3'b110 : p1 == 2 ? 3'b111 : 3'($urandom);
      cyc(1'($urandom), 1'($urandom), rf0, rf1, $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 3) != 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
